// File: rtl/dsp_addsub_arbiter_if.sv
// Request/response channels between the pipeline requesters and the add/sub arbiter.
interface dsp_addsub_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_op1;
  logic [32*NREQ-1:0]   req_op2;
  logic [NREQ-1:0]      req_sub;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [31:0]          resp_data;

  modport master (
    output req_valid, req_op1, req_op2, req_sub, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_sub, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dsp_addsub_arbiter.sv
// Round-robin sharing of one combinational 32-bit add/sub DSP among NREQ requesters; 3 cycles/op.
// Optional counters stat_ops/stat_stall are built only when DSP_ARB_STATS_EN is defined.
module dsp_addsub_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dsp_addsub_arbiter_if.slave  bus,
  output logic [31:0]          dsp_in1,
  output logic [31:0]          dsp_in2,
  output logic                 dsp_addorsub,
  input  logic [31:0]          dsp_out,
  output logic [31:0]          stat_ops,
  output logic [31:0]          stat_stall
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, owner, grant_idx, owner_nxt;
  logic [NREQ-1:0] grant;
  logic            grant_any, resp_hs;
  logic [31:0]     op1_q, op2_q, result_q;
  logic            sub_q;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PW'(idx);
      end
    end
  end

  assign resp_hs   = (state_q == RESP) && bus.resp_ready[owner];
  assign owner_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is asserted, even mid-operation.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    if (!reset) begin
      if (state_q == IDLE) bus.req_ready = grant;
      if (state_q == RESP) bus.resp_valid[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op1_q    <= '0;
      op2_q    <= '0;
      sub_q    <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && grant_any) begin
        op1_q <= bus.req_op1[32*int'(grant_idx) +: 32];
        op2_q <= bus.req_op2[32*int'(grant_idx) +: 32];
        sub_q <= bus.req_sub[grant_idx];
        owner <= grant_idx;
      end
      if (state_q == EXEC) result_q <= dsp_out;
      if (resp_hs)         rr_ptr   <= owner_nxt;
    end
  end

  // DSP inputs come straight from the operand registers, so they hold outside EXEC.
  assign dsp_in1       = op1_q;
  assign dsp_in2       = op2_q;
  assign dsp_addorsub  = sub_q;
  assign bus.resp_data = result_q;

`ifdef DSP_ARB_STATS_EN
  logic stall_cyc;
  assign stall_cyc = |(bus.req_valid & ~bus.req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (resp_hs && stat_ops != 32'hFFFF_FFFF)     stat_ops   <= stat_ops + 32'd1;
      if (stall_cyc && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
    end
  end
`else
  assign stat_ops   = '0;
  assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Randomized and directed checks of dsp_addsub_arbiter against a transaction-level reference.
module tb_dsp_addsub_arbiter;
  localparam int NREQ = 2;
`ifdef DSP_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dsp_in1, dsp_in2, dsp_out, stat_ops, stat_stall;
  logic        dsp_addorsub;

  always #5 clk = ~clk;

  dsp_addsub_arbiter_if #(.NREQ(NREQ)) bus();

  // Behavioural stand-in for the combinational DSP.
  assign dsp_out = dsp_addorsub ? (dsp_in1 - dsp_in2) : (dsp_in1 + dsp_in2);

  dsp_addsub_arbiter #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dsp_in1      (dsp_in1),
    .dsp_in2      (dsp_in2),
    .dsp_addorsub (dsp_addorsub),
    .dsp_out      (dsp_out),
    .stat_ops     (stat_ops),
    .stat_stall   (stat_stall)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side stimulus.
  logic [NREQ-1:0] vld, rsp_rdy;
  logic [31:0]     a[NREQ];
  logic [31:0]     b[NREQ];
  logic            s[NREQ];

  // Reference model: one operation in flight, counted in cycles since its grant.
  bit              m_busy;
  int              m_age, m_owner, m_ptr;
  logic [31:0]     m_a, m_b, m_res, m_last, m_ops, m_stall;
  bit              m_s;
  logic [NREQ-1:0] m_hs;
  int              gnt_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_ops(input int i);
    a[i] = rnd32();
    b[i] = rnd32();
    s[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic apply();
    bus.req_valid  = vld;
    bus.resp_ready = rsp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op1[32*i +: 32] = a[i];
      bus.req_op2[32*i +: 32] = b[i];
      bus.req_sub[i]          = s[i];
    end
  endtask

  task automatic model_cycle();
    logic [NREQ-1:0] exp_rdy;
    exp_rdy = '0;
    m_hs    = '0;
    if (reset) begin
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_ops   = '0;
      m_stall = '0;
      return;
    end
    check("stat_ops", stat_ops, STATS ? m_ops : 32'd0);
    check("stat_stall", stat_stall, STATS ? m_stall : 32'd0);
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (exp_rdy == '0 && vld[idx]) exp_rdy[idx] = 1'b1;
      end
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
      if (exp_rdy != '0) begin
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) m_owner = i;
        m_a    = a[m_owner];
        m_b    = b[m_owner];
        m_s    = s[m_owner];
        m_res  = m_s ? (m_a - m_b) : (m_a + m_b);
        m_busy = 1'b1;
        m_age  = 0;
        m_hs   = exp_rdy;
        gnt_log.push_back(m_owner);
      end
    end else begin
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (m_age == 1) begin
        check("dsp_in1", dsp_in1, m_a);
        check("dsp_in2", dsp_in2, m_b);
        check("dsp_addorsub", 32'(dsp_addorsub), 32'(m_s));
        check("resp_valid_exec", 32'(bus.resp_valid), 32'd0);
      end else begin
        check("resp_valid", 32'(bus.resp_valid), 32'(1 << m_owner));
        check("resp_data", bus.resp_data, m_res);
        if (rsp_rdy[m_owner]) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
          m_ops  = m_ops + 32'd1;
          m_last = bus.resp_data;
        end
      end
    end
    if ((vld & ~exp_rdy) != '0) m_stall = m_stall + 32'd1;
    m_age++;
  endtask

  task automatic step();
    apply();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_hs[i] && n < 20);
    if (!m_hs[i]) check("tmo_grant", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_busy && n < 40);
    if (m_busy) check("tmo_idle", 32'd0, 32'd1);
  endtask

  task automatic do_op(input int i, input logic [31:0] x, input logic [31:0] y,
                       input logic sub, input logic [31:0] expect_val, input string tag);
    a[i]   = x;
    b[i]   = y;
    s[i]   = sub;
    vld[i] = 1'b1;
    wait_grant(i);
    vld[i]  = 1'b0;
    rsp_rdy = '1;
    wait_idle();
    check(tag, m_last, expect_val);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    vld     = '0;
    rsp_rdy = '1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    m_busy  = 1'b0;
    m_ptr   = 0;
    m_age   = 0;
    m_owner = 0;
    m_ops   = '0;
    m_stall = '0;
    m_last  = '0;
    m_hs    = '0;
    reset   = 1'b1;
    apply();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    check("rst_dsp_in1", dsp_in1, 32'd0);
    check("rst_dsp_in2", dsp_in2, 32'd0);
    check("rst_dsp_addorsub", 32'(dsp_addorsub), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);

    // Contention: both requesters valid continuously from the first cycle after reset.
    gnt_log.delete();
    vld = '1;
    n = 0;
    while (m_ops < 32'd4 && n < 100) begin
      step();
      n++;
      for (int i = 0; i < NREQ; i++) if (m_hs[i]) new_ops(i);
    end
    check("cont_ngrants", 32'(gnt_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++)
      check("cont_order", 32'(gnt_log[k]), 32'(k % 2));
    check("stat_ops_4", stat_ops, STATS ? 32'd4 : 32'd0);
    check("stat_stall_4", stat_stall, STATS ? 32'(n) : 32'd0);
    vld = '0;
    wait_idle();

    // Directed single add and wrap cases.
    do_op(0, 32'h5, 32'h3, 1'b0, 32'h8, "add_5_3");
    do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, "wrap_add");
    do_op(0, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF, "wrap_sub");
    do_op(1, 32'h0001_0000, 32'h1, 1'b1, 32'h0000_FFFF, "sub_half_carry");

    // Response backpressure with a waiting contender and a non-owner resp_ready.
    a[0] = 32'h1234_5678; b[0] = 32'h1111_1111; s[0] = 1'b1;
    vld[0] = 1'b1;
    wait_grant(0);
    vld[0] = 1'b0;
    vld[1] = 1'b1;
    new_ops(1);
    rsp_rdy = 2'b10;
    g = gnt_log.size();
    for (int k = 0; k < 6; k++) step();
    check("bp_held", 32'(m_busy), 32'd1);
    check("bp_no_grant", 32'(gnt_log.size()), 32'(g));
    check("bp_data", bus.resp_data, 32'h0123_4567);
    rsp_rdy = '1;
    wait_grant(1);
    check("bp_next_owner", 32'(gnt_log[$]), 32'd1);
    vld = '0;
    wait_idle();

    // Reset during EXEC: operation dropped, pointer back to requester 0.
    a[0] = 32'h77; b[0] = 32'h11; s[0] = 1'b0;
    vld[0] = 1'b1;
    wait_grant(1'b0);
    vld   = '1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstx_dsp_in1", dsp_in1, 32'd0);
    check("rstx_resp_valid", 32'(bus.resp_valid), 32'd0);
    step();
    check("rstx_next_grant", 32'(m_hs), 32'd1);
    vld = '0;
    wait_idle();

    // Randomized traffic with random backpressure and occasional withdrawal.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_hs[i] || !vld[i]) begin
          vld[i] = 1'($urandom_range(0, 1));
          new_ops(i);
        end else if ($urandom_range(0, 15) == 0) begin
          vld[i] = 1'b0;
        end
      end
      rsp_rdy = NREQ'($urandom);
      step();
    end
    vld     = '0;
    rsp_rdy = '1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
